// File: rtl/instr_fetch_unit_if.sv
// Bus bundle between the fetch sequencer and its surroundings (control unit,
// PC register, memory port, PC source path).
//
// Handshake: fetch_start is a request that is taken only while busy=0; the
// unit acknowledges an accepted, aligned request by raising mem_read on the
// following cycle. A request seen while busy=1 is dropped, never queued.
// ir_valid, pc_write_req and align_fault are single-cycle pulses with no
// back-pressure; the receiver must sample them in the cycle they are high.
interface instr_fetch_unit_if;
  logic        fetch_start;
  logic [31:0] pc_in;
  logic [31:0] mem_rdata;
  logic [31:0] mem_addr;
  logic        mem_read;
  logic [31:0] ir_out;
  logic        ir_valid;
  logic [31:0] pc_next;
  logic        pc_write_req;
  logic        busy;
  logic        align_fault;
  logic [1:0]  state_dbg;

  modport master (
    input  fetch_start, pc_in, mem_rdata,
    output mem_addr, mem_read, ir_out, ir_valid, pc_next, pc_write_req,
           busy, align_fault, state_dbg
  );

  modport slave (
    output fetch_start, pc_in, mem_rdata,
    input  mem_addr, mem_read, ir_out, ir_valid, pc_next, pc_write_req,
           busy, align_fault, state_dbg
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch sequencer for the multi-cycle MIPS datapath. Latches the PC on an
// accepted request, holds the memory read for MEM_LATENCY cycles, captures
// the instruction word, then pulses a PC-write request carrying PC+PC_INC.
module instr_fetch_unit #(
  parameter int          MEM_LATENCY = 3,
  parameter logic [31:0] PC_INC      = 32'd4
) (
  input  logic           clk,
  input  logic           reset,
  instr_fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  // Counter starts at MEM_LATENCY-1 so that READ lasts exactly MEM_LATENCY
  // cycles; the last READ cycle is the one where the counter reads 0.
  localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q;
  logic [31:0] addr_q;
  logic [31:0] pc_next_q;
  logic [31:0] ir_q;
  logic        align_fault_q;
  logic        req_idle;
  logic        aligned;
  logic        accept;
  logic        last_read;

  assign req_idle  = (state_q == IDLE) && bus.fetch_start;
  assign aligned   = (bus.pc_in[1:0] == 2'b00);
  assign accept    = req_idle && aligned;
  assign last_read = (state_q == READ) && (cnt_q == 4'd0);

  // State register; reset wins over everything, aborting any fetch in flight.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)    state_d = READ;
      READ:    if (last_read) state_d = CAPTURE;
      CAPTURE:                state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Datapath: latched address/PC+4, wait counter, instruction register and
  // the registered misalignment pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q        <= 32'd0;
      pc_next_q     <= 32'd0;
      ir_q          <= 32'd0;
      cnt_q         <= 4'd0;
      align_fault_q <= 1'b0;
    end else begin
      align_fault_q <= req_idle && !aligned;
      if (accept) begin
        addr_q    <= bus.pc_in;
        pc_next_q <= bus.pc_in + PC_INC;
        cnt_q     <= CNT_INIT;
      end else if ((state_q == READ) && (cnt_q != 4'd0)) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (last_read) ir_q <= bus.mem_rdata;
    end
  end

  assign bus.mem_addr     = addr_q;
  assign bus.pc_next      = pc_next_q;
  assign bus.ir_out       = ir_q;
  assign bus.align_fault  = align_fault_q;
  assign bus.mem_read     = (state_q == READ);
  assign bus.ir_valid     = (state_q == CAPTURE);
  assign bus.pc_write_req = (state_q == CAPTURE);
  assign bus.busy         = (state_q != IDLE);
  assign bus.state_dbg    = state_q;

endmodule
